// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: word-wide on-chip RAM with programmable wait states and a one-cycle
// ready pulse. Define LC3_MMIO_EN to map SW (read) and HEX_Data (write) at address 16'hFFFF.
module lc3_mem_responder #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MIO_EN,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_to_mem,
  input  logic [15:0] SW,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic [15:0] HEX_Data
);

  localparam int unsigned AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [16:0] MemLimit = 17'(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StHold} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          capture;
  logic [15:0]   addr_q, wdata_q;
  logic          we_q;
  logic          io_sel, mem_sel, access;
  logic [AW-1:0] idx;
  logic [15:0]   rd_data;
  logic [15:0]   mdr_q;
  logic          r_q;
  logic [15:0]   mem [MEM_WORDS];

  assign io_sel  = (addr_q == 16'hFFFF);
  assign mem_sel = ({1'b0, addr_q} < MemLimit) && !io_sel;
  assign idx     = addr_q[AW-1:0];
  assign access  = (state_q == StAccess);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MIO_EN) begin
          capture = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StAccess;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StAccess: state_d = StHold;
      StHold:   if (!MIO_EN) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are frozen at capture so bus activity during WAIT has no effect.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
    end else if (capture) begin
      addr_q  <= ADDR;
      wdata_q <= Data_to_mem;
      we_q    <= WE;
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    if (mem_sel) rd_data = mem[idx];
`ifdef LC3_MMIO_EN
    if (io_sel) rd_data = SW;
`endif
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_q   <= 1'b0;
      mdr_q <= 16'h0000;
    end else begin
      r_q <= access;
      if (access && !we_q) mdr_q <= rd_data;
    end
  end

  // Array has no reset so contents survive Reset.
  always_ff @(posedge Clk) begin
    if (access && we_q && mem_sel) mem[idx] <= wdata_q;
  end

`ifdef LC3_MMIO_EN
  logic [15:0] hex_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hex_q <= 16'h0000;
    end else if (access && we_q && io_sel) begin
      hex_q <= wdata_q;
    end
  end

  assign HEX_Data = hex_q;
`else
  logic unused_sw;
  assign unused_sw = ^SW;
  assign HEX_Data  = 16'h0000;
`endif

  assign MDR_In = mdr_q;
  assign R      = r_q;

endmodule
